cam_pattern_stream: RTL
=======================

# cam_pattern_stream

Configurable test-pattern video source driven by the cam_axi control registers. It emits frames as a 32-bit AXI4-Stream video sequence toward the VDMA S2MM write channel:
- TUSER marks start of frame.
- TLAST marks end of line.

It sits directly downstream of the cam_axi AXI4-Lite register slave, which supplies its configuration, and returns status that the slave exposes on reads.

## Interface
Parameters:
- HBLANK, 4: idle cycles inserted after each line's TLAST beat; 0 is legal.
- VBLANK, 16: idle cycles inserted after each frame's final beat; 0 is legal.
- DIM_W, 16: width of the frame dimension inputs.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- cfg_enable  in  1  run request (register 0, bit 0).
- cfg_width  in  DIM_W  pixels per line (register 1).
- cfg_height  in  DIM_W  lines per frame (register 2).
- cfg_pattern  in  2  pattern select (register 3, bits 1:0).
- cfg_color  in  32  solid colour value (register 3, bits 31:0 reused; bits 1:0 also feed pattern select).
- M_AXIS_TDATA  out  32  pixel data.
- M_AXIS_TVALID  out  1  beat valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TLAST  out  1  last pixel of a line.
- M_AXIS_TUSER  out  1  first pixel of a frame.
- busy  out  1  high while a frame is in progress, including blanking.
- frame_done  out  1  one-cycle pulse per completed frame.
- frame_count  out  32  completed frames since reset; wraps at 2^32.

## Operation
- FSM states: IDLE, ACTIVE, HBLANK_S, VBLANK_S.
- **IDLE**
  - If cfg_enable=1 and both cfg_width and cfg_height are nonzero, latch width, height, pattern and colour, clear x/y, then enter ACTIVE.
  - If either dimension is zero, remain in IDLE.
- **ACTIVE**
  - Present pixel (x,y). Advance only on TVALID&TREADY.
  - On the handshake of x=width-1:
    - If y<height-1: enter HBLANK_S (or ACTIVE at x=0, y+1 when HBLANK=0).
    - If y=height-1: pulse frame_done, increment frame_count, enter VBLANK_S (or the frame-start decision when VBLANK=0).
- **HBLANK_S**: count HBLANK cycles, then enter ACTIVE with x=0, y=y+1.
- **VBLANK_S**: count VBLANK cycles, then make the frame-start decision:
  - cfg_enable=1 and valid dimensions: relatch config, start a new frame.
  - Otherwise: go to IDLE.
- **Enable and config changes**
  - Deasserting cfg_enable mid-frame does not truncate: the frame completes, including VBLANK.
  - Config changes take effect only at the frame-start decision.
- **Beat flags**: TUSER=1 only on (0,0); TLAST=1 only when x=width-1; both hold for a 1x1 frame.
- **Patterns** (x and y are DIM_W wide):
  - 0: cfg_color.
  - 1: zero-extended x.
  - 2: zero-extended y.
  - 3: {frame_count[7:0], y[7:0], x[15:0]}, where frame_count is the value before this frame's increment.
- **Arithmetic**: x and y comparisons against width-1 and height-1 are unsigned at DIM_W. The blanking counter is $clog2(max(HBLANK,VBLANK)+1) bits.

## Timing
- All outputs are registered. Reset values: TVALID=0, TLAST=0, TUSER=0, TDATA=0, busy=0, frame_done=0, frame_count=0, FSM=IDLE.
- Start latency: cfg_enable sampled high in IDLE at edge N gives TVALID=1 with TUSER=1 after edge N; the first beat is visible in cycle N+1.
- Once TVALID is asserted, TDATA, TLAST and TUSER stay stable until the handshake; TVALID is never withdrawn without one.
- Throughput: the next beat in a line is presented in the cycle after the handshake, so a held-high TREADY gives one pixel per cycle.
- HBLANK=h>0: exactly h cycles with TVALID=0 between a TLAST handshake and the next line's first beat. With h=0 there is no gap.
- frame_done is high in the cycle immediately after the final beat's handshake; frame_count updates on the same edge.
- busy rises with the first TVALID and falls on entry to IDLE.
- ARESET asserted at any time, including mid-beat with TVALID=1: all outputs drop to their reset values asynchronously. Operation resumes from IDLE after ARESET deasserts.

## Structure
- Package cam_pattern_pkg holds:
  - state_t enum: IDLE, ACTIVE, HBLANK_S, VBLANK_S.
  - Pattern codes: PAT_SOLID=0, PAT_HRAMP=1, PAT_VRAMP=2, PAT_COUNT=3.
- Sub-module cam_xy_counter: x/y position counters with advance, clear and next_line inputs and end_of_line/end_of_frame outputs.
- Top-level block: FSM, blanking counter, pattern mux and output register.

## Test plan
- 4x2 frame, pattern 1, TREADY=1, HBLANK=4 -> TDATA 0,1,2,3 with TLAST on 3 and TUSER on the first beat only; 4 idle cycles; then 0..3; frame_done pulses; frame_count=1.
- 1x1 frame, pattern 0, cfg_color=0xDEADBEEF -> single beat 0xDEADBEEF with TUSER=1 and TLAST=1.
- 3x1 frame with TREADY toggling every cycle -> TVALID and TDATA held stable while TREADY=0; exactly 3 handshakes.
- cfg_enable dropped after 2 beats of a 4x2 frame -> all 8 beats delivered; after VBLANK the FSM returns to IDLE and busy=0.
- Pattern 3, 2x2, two consecutive frames -> second frame's beats carry TDATA[31:24]=0x01; frame_count=2.
- ARESET pulsed while TVALID=1 mid-line -> outputs zero immediately, frame_count=0; a new frame restarts with TUSER=1 at (0,0).

Source files
------------

// File: rtl/cam_pattern_stream_pkg.sv
// Shared types and constants for the test-pattern video source.
package cam_pattern_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK_S, VBLANK_S} state_t;

  localparam logic [1:0] PAT_SOLID = 2'd0;
  localparam logic [1:0] PAT_HRAMP = 2'd1;
  localparam logic [1:0] PAT_VRAMP = 2'd2;
  localparam logic [1:0] PAT_COUNT = 2'd3;

  // Blanking counter width; kept at least 1 bit when both blanks are zero.
  function automatic int blank_cnt_w(input int hb, input int vb);
    int mx;
    mx = (hb > vb) ? hb : vb;
    return (mx < 1) ? 1 : $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/cam_pattern_stream_if.sv
// 32-bit AXI4-Stream video channel: tuser = start of frame, tlast = end of line.
interface cam_pattern_stream_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/cam_pattern_stream_xy_counter.sv
// Pixel position counters; x_nxt/y_nxt expose the position being loaded this edge.
module cam_xy_counter #(
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  input  logic             next_line,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  output logic [DIM_W-1:0] x_nxt,
  output logic [DIM_W-1:0] y_nxt,
  output logic             end_of_line,
  output logic             end_of_frame
);

  localparam logic [DIM_W-1:0] ONE = 1;

  logic [DIM_W-1:0] x;
  logic [DIM_W-1:0] y;

  always_comb begin
    x_nxt = x;
    y_nxt = y;
    if (clear) begin
      x_nxt = '0;
      y_nxt = '0;
    end else if (next_line) begin
      x_nxt = '0;
      y_nxt = y + ONE;
    end else if (advance) begin
      x_nxt = x + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= x_nxt;
      y <= y_nxt;
    end
  end

  assign end_of_line  = (x == width - ONE);
  assign end_of_frame = end_of_line && (y == height - ONE);

endmodule

// File: rtl/cam_pattern_stream.sv
// Test-pattern frame source: FSM, blanking counter, pattern mux and registered AXIS beat.
module cam_pattern_stream
  import cam_pattern_pkg::*;
#(
  parameter int HBLANK = 4,
  parameter int VBLANK = 16,
  parameter int DIM_W  = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 cfg_enable,
  input  logic [DIM_W-1:0]     cfg_width,
  input  logic [DIM_W-1:0]     cfg_height,
  input  logic [1:0]           cfg_pattern,
  input  logic [31:0]          cfg_color,
  cam_pattern_stream_if.master M_AXIS,
  output logic                 busy,
  output logic                 frame_done,
  output logic [31:0]          frame_count
);

  localparam int CW = blank_cnt_w(HBLANK, VBLANK);
  localparam logic [CW-1:0]    HB_LAST = CW'((HBLANK > 0) ? HBLANK - 1 : 0);
  localparam logic [CW-1:0]    VB_LAST = CW'((VBLANK > 0) ? VBLANK - 1 : 0);
  localparam logic [DIM_W-1:0] ONE     = 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [DIM_W-1:0] w_q, h_q;
  logic [1:0]       pat_q;
  logic [31:0]      color_q;
  logic [31:0]      tdata_q;
  logic             tvalid_q, tlast_q, tuser_q;

  logic [DIM_W-1:0] x_nxt, y_nxt, use_w;
  logic             eol, eof;
  logic             cfg_ok, fire, last_beat, hb_done, vb_done, decide, start;
  logic             next_line, advance, load, tlast_nxt;
  logic [1:0]       use_pat;
  logic [31:0]      use_col, fc_nxt, x32, y32, pix;

  always_comb begin
    cfg_ok    = cfg_enable && (cfg_width != '0) && (cfg_height != '0);
    fire      = (state == ACTIVE) && tvalid_q && M_AXIS.tready;
    last_beat = fire && eof;
    hb_done   = (state == HBLANK_S) && (cnt == HB_LAST);
    vb_done   = (state == VBLANK_S) && (cnt == VB_LAST);
    decide    = (state == IDLE) || vb_done || (last_beat && (VBLANK == 0));
    start     = decide && cfg_ok;
    next_line = hb_done || (fire && eol && !eof && (HBLANK == 0));
    advance   = fire && !eol;
    load      = start || next_line || advance;
    // Pattern 3 must see the count as it stands once this edge has committed.
    fc_nxt    = frame_count + {31'd0, last_beat};
    use_w     = start ? cfg_width   : w_q;
    use_pat   = start ? cfg_pattern : pat_q;
    use_col   = start ? cfg_color   : color_q;
    x32       = 32'(x_nxt);
    y32       = 32'(y_nxt);
    tlast_nxt = (x_nxt == use_w - ONE);
    case (use_pat)
      PAT_SOLID: pix = use_col;
      PAT_HRAMP: pix = x32;
      PAT_VRAMP: pix = y32;
      PAT_COUNT: pix = {fc_nxt[7:0], y32[7:0], x32[15:0]};
      default:   pix = use_col;
    endcase
  end

  cam_xy_counter #(.DIM_W(DIM_W)) u_xy (
    .clk          (ACLK),
    .rst          (ARESET),
    .clear        (start),
    .advance      (advance),
    .next_line    (next_line),
    .width        (w_q),
    .height       (h_q),
    .x_nxt        (x_nxt),
    .y_nxt        (y_nxt),
    .end_of_line  (eol),
    .end_of_frame (eof)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state       <= IDLE;
      cnt         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      pat_q       <= PAT_SOLID;
      color_q     <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= last_beat;
      if (last_beat) frame_count <= fc_nxt;

      if (start) begin
        w_q     <= cfg_width;
        h_q     <= cfg_height;
        pat_q   <= cfg_pattern;
        color_q <= cfg_color;
        busy    <= 1'b1;
      end

      if (load) begin
        tvalid_q <= 1'b1;
        tdata_q  <= pix;
        tlast_q  <= tlast_nxt;
        tuser_q  <= start;
      end else if (fire) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
        tuser_q  <= 1'b0;
      end

      case (state)
        IDLE: if (start) state <= ACTIVE;
        ACTIVE: begin
          if (fire && eol) begin
            if (!eof) begin
              if (HBLANK != 0) begin
                state <= HBLANK_S;
                cnt   <= '0;
              end
            end else if (VBLANK != 0) begin
              state <= VBLANK_S;
              cnt   <= '0;
            end else if (!start) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        HBLANK_S: begin
          if (hb_done) state <= ACTIVE;
          else         cnt   <= cnt + 1'b1;
        end
        VBLANK_S: begin
          if (vb_done) begin
            if (start) begin
              state <= ACTIVE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign M_AXIS.tdata  = tdata_q;
  assign M_AXIS.tvalid = tvalid_q;
  assign M_AXIS.tlast  = tlast_q;
  assign M_AXIS.tuser  = tuser_q;

endmodule
